// File: rtl/freelist_pkg.sv
// Shared widths and types for the physical-register free list.
// Build-level overrides of the configuration macros take precedence over these defaults.
`ifndef PHY_REG_NUM
`define PHY_REG_NUM 64
`endif
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 4
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

package freelist_pkg;
    localparam int PHY_REG_NUM         = `PHY_REG_NUM;
    localparam int ARCH_REG_NUM        = 32;
    localparam int RENAME_WIDTH        = `RENAME_WIDTH;
    localparam int COMMIT_WIDTH        = `COMMIT_WIDTH;
    localparam int PHY_REG_ID_WIDTH    = $clog2(PHY_REG_NUM);
    localparam int FREELIST_INIT_COUNT = PHY_REG_NUM - ARCH_REG_NUM;

    typedef logic [PHY_REG_ID_WIDTH-1:0] phy_id_t;
    // Extra MSB separates a full buffer from an empty one.
    typedef logic [PHY_REG_ID_WIDTH:0]   fl_ptr_t;
endpackage

// File: rtl/phy_id_freelist_if.sv
// Rename/commit-facing signals of the free list; master is the pipeline, slave is the free list.
interface phy_id_freelist_if #(
    parameter int RW = freelist_pkg::RENAME_WIDTH,
    parameter int CW = freelist_pkg::COMMIT_WIDTH
);
    import freelist_pkg::*;

    logic [RW-1:0] rename_freelist_req;
    phy_id_t       freelist_rename_id [RW];
    logic          freelist_rename_ready;
    logic [CW-1:0] commit_freelist_valid;
    phy_id_t       commit_freelist_old_id [CW];
    logic          commit_freelist_restore;
    fl_ptr_t       freelist_free_count;
    logic          freelist_overflow_err;

    modport master (
        output rename_freelist_req, commit_freelist_valid, commit_freelist_old_id,
               commit_freelist_restore,
        input  freelist_rename_id, freelist_rename_ready, freelist_free_count,
               freelist_overflow_err
    );

    modport slave (
        input  rename_freelist_req, commit_freelist_valid, commit_freelist_old_id,
               commit_freelist_restore,
        output freelist_rename_id, freelist_rename_ready, freelist_free_count,
               freelist_overflow_err
    );
endinterface

// File: rtl/freelist_prefix_count.sv
// Exclusive prefix popcount of an N-bit vector, plus the total count.
// prefix[i] = number of set bits strictly below position i.
module freelist_prefix_count #(
    parameter int N = 4,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] prefix [N],
    output logic [W-1:0] total
);
    always_comb begin
        logic [W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i] = acc;
            acc       = acc + W'(vec[i]);
        end
        total = acc;
    end
endmodule

// File: rtl/phy_id_freelist.sv
// Physical-register free list: circular buffer of unmapped phy ids with a speculative
// allocation head, a committed head and a release tail; flush rewinds the speculative head.
module phy_id_freelist #(
    parameter int PHY_REG_NUM  = freelist_pkg::PHY_REG_NUM,
    parameter int ARCH_REG_NUM = freelist_pkg::ARCH_REG_NUM,
    parameter int RENAME_WIDTH = freelist_pkg::RENAME_WIDTH,
    parameter int COMMIT_WIDTH = freelist_pkg::COMMIT_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    phy_id_freelist_if.slave  fl
);
    import freelist_pkg::*;

    localparam int PTR_W = PHY_REG_ID_WIDTH + 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int RCW   = $clog2(RENAME_WIDTH + 1);
    localparam int CCW   = $clog2(COMMIT_WIDTH + 1);
    localparam int INIT  = PHY_REG_NUM - ARCH_REG_NUM;

    phy_id_t         entry [PHY_REG_NUM];
    fl_ptr_t         spec_head;
    fl_ptr_t         arch_head;
    fl_ptr_t         tail;
    fl_ptr_t         free_count;
    fl_ptr_t         occupancy;
    logic [RCW-1:0]  req_prefix [RENAME_WIDTH];
    logic [RCW-1:0]  req_total;
    logic [CCW-1:0]  commit_prefix [COMMIT_WIDTH];
    logic [CCW-1:0]  commit_total;
    logic            ready;
    logic            grant;
    logic            overflow;
    logic            overflow_err;

    freelist_prefix_count #(.N(RENAME_WIDTH), .W(RCW)) u_req_count (
        .vec    (fl.rename_freelist_req),
        .prefix (req_prefix),
        .total  (req_total)
    );

    freelist_prefix_count #(.N(COMMIT_WIDTH), .W(CCW)) u_commit_count (
        .vec    (fl.commit_freelist_valid),
        .prefix (commit_prefix),
        .total  (commit_total)
    );

    assign free_count = tail - spec_head;
    assign occupancy  = tail - arch_head;

    always_comb begin
        ready    = !fl.commit_freelist_restore && (free_count >= PTR_W'(req_total));
        grant    = ready && (|fl.rename_freelist_req);
        // Widened so a bad commit burst cannot wrap past the limit unnoticed.
        overflow = (OCC_W'(occupancy) + OCC_W'(commit_total)) > OCC_W'(INIT);
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            fl.freelist_rename_id[k] =
                entry[PHY_REG_ID_WIDTH'(spec_head + PTR_W'(req_prefix[k]))];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < PHY_REG_NUM; i++) begin
                entry[i] <= (i < INIT) ? PHY_REG_ID_WIDTH'(ARCH_REG_NUM + i) : '0;
            end
            spec_head    <= '0;
            arch_head    <= '0;
            tail         <= PTR_W'(INIT);
            overflow_err <= 1'b0;
        end else begin
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (fl.commit_freelist_valid[j]) begin
                    entry[PHY_REG_ID_WIDTH'(tail + PTR_W'(commit_prefix[j]))]
                        <= fl.commit_freelist_old_id[j];
                end
            end
            tail      <= tail + PTR_W'(commit_total);
            arch_head <= arch_head + PTR_W'(commit_total);
            // Flush lands on the committed head including this cycle's retirements.
            if (fl.commit_freelist_restore) begin
                spec_head <= arch_head + PTR_W'(commit_total);
            end else if (grant) begin
                spec_head <= spec_head + PTR_W'(req_total);
            end
            if (overflow) begin
                overflow_err <= 1'b1;
            end
        end
    end

    assign fl.freelist_rename_ready = ready;
    assign fl.freelist_free_count   = free_count;
    assign fl.freelist_overflow_err = overflow_err;
endmodule

// File: tb/tb_phy_id_freelist.sv
// Randomized and directed checks of phy_id_freelist against a queue model of the free ids.
module tb_phy_id_freelist;
    import freelist_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    phy_id_freelist_if fl();

    phy_id_freelist dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: q holds the ids from the committed head to the tail in order;
    // spec_n of them have been handed out speculatively.
    int q[$];
    int spec_n;
    bit m_err;
    bit model_en = 1'b1;

    function automatic int pc(input logic [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_init();
        q.delete();
        for (int i = 0; i < FREELIST_INIT_COUNT; i++) q.push_back(ARCH_REG_NUM + i);
        spec_n = 0;
        m_err  = 1'b0;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            model_init();
        end else if (model_en) begin
            int pr;
            int pv;
            bit rdy;
            pr  = pc(32'(fl.rename_freelist_req));
            pv  = pc(32'(fl.commit_freelist_valid));
            if (q.size() + pv > FREELIST_INIT_COUNT) m_err = 1'b1;
            rdy = !fl.commit_freelist_restore && (q.size() - spec_n >= pr);
            if (rdy) spec_n += pr;
            for (int k = 0; k < pv; k++) if (q.size() > 0) void'(q.pop_front());
            spec_n -= pv;
            for (int j = 0; j < COMMIT_WIDTH; j++)
                if (fl.commit_freelist_valid[j]) q.push_back(int'(fl.commit_freelist_old_id[j]));
            if (fl.commit_freelist_restore) spec_n = 0;
        end
    end

    always @(negedge clk) begin
        if (rst && model_en) begin
            int pr;
            int fc;
            int rank;
            bit rdy;
            fc  = q.size() - spec_n;
            pr  = pc(32'(fl.rename_freelist_req));
            rdy = !fl.commit_freelist_restore && (fc >= pr);
            chk("model_free_count", 32'(fl.freelist_free_count), fc);
            chk("model_ready", 32'(fl.freelist_rename_ready), 32'(rdy));
            chk("model_overflow_err", 32'(fl.freelist_overflow_err), 32'(m_err));
            rank = 0;
            for (int k = 0; k < RENAME_WIDTH; k++) begin
                if (fl.rename_freelist_req[k]) begin
                    if (spec_n + rank < q.size())
                        chk($sformatf("model_rename_id[%0d]", k),
                            32'(fl.freelist_rename_id[k]), q[spec_n + rank]);
                    rank++;
                end
            end
        end
    end

    task automatic clear_in();
        fl.rename_freelist_req     = '0;
        fl.commit_freelist_valid   = '0;
        fl.commit_freelist_restore = 1'b0;
        for (int j = 0; j < COMMIT_WIDTH; j++) fl.commit_freelist_old_id[j] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    initial begin
        clear_in();

        // Reset state and a full-width allocation
        do_reset();
        chk("reset_free_count", 32'(fl.freelist_free_count), 32);
        chk("reset_overflow_err", 32'(fl.freelist_overflow_err), 0);
        chk("reset_ready_zero_req", 32'(fl.freelist_rename_ready), 1);
        fl.rename_freelist_req = 4'b1111;
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("alloc4_id[%0d]", k), 32'(fl.freelist_rename_id[k]), 32 + k);
        chk("alloc4_ready", 32'(fl.freelist_rename_ready), 1);
        chk("alloc4_free_before", 32'(fl.freelist_free_count), 32);
        step();
        fl.rename_freelist_req = '0;
        #1;
        chk("alloc4_free_after", 32'(fl.freelist_free_count), 28);
        chk("alloc4_next_id", 32'(fl.freelist_rename_id[0]), 36);

        // Sparse request
        do_reset();
        fl.rename_freelist_req = 4'b1010;
        #1;
        chk("sparse_slot1", 32'(fl.freelist_rename_id[1]), 32);
        chk("sparse_slot3", 32'(fl.freelist_rename_id[3]), 33);
        step();
        fl.rename_freelist_req = '0;
        #1;
        chk("sparse_free_after", 32'(fl.freelist_free_count), 30);
        chk("sparse_next_id", 32'(fl.freelist_rename_id[0]), 34);

        // Drain to empty
        do_reset();
        fl.rename_freelist_req = 4'b1111;
        repeat (8) step();
        fl.rename_freelist_req = 4'b0001;
        #1;
        chk("empty_free_count", 32'(fl.freelist_free_count), 0);
        chk("empty_ready", 32'(fl.freelist_rename_ready), 0);
        step();
        fl.rename_freelist_req = '0;
        #1;
        chk("empty_no_move", 32'(fl.freelist_free_count), 0);
        chk("empty_zero_req_ready", 32'(fl.freelist_rename_ready), 1);

        // Release while empty: visible only next cycle
        fl.rename_freelist_req       = 4'b0011;
        fl.commit_freelist_valid     = 4'b0011;
        fl.commit_freelist_old_id[0] = 6'd5;
        fl.commit_freelist_old_id[1] = 6'd7;
        #1;
        chk("release_no_bypass", 32'(fl.freelist_rename_ready), 0);
        step();
        fl.commit_freelist_valid = '0;
        #1;
        chk("release_free_count", 32'(fl.freelist_free_count), 2);
        chk("release_ready", 32'(fl.freelist_rename_ready), 1);
        chk("release_id0", 32'(fl.freelist_rename_id[0]), 5);
        chk("release_id1", 32'(fl.freelist_rename_id[1]), 7);
        step();
        clear_in();

        // Flush with same-cycle commit
        do_reset();
        fl.rename_freelist_req = 4'b1111;
        step();
        fl.rename_freelist_req = 4'b0011;
        step();
        fl.rename_freelist_req = '0;
        #1;
        chk("flush_pre_id", 32'(fl.freelist_rename_id[0]), 38);
        chk("flush_pre_free", 32'(fl.freelist_free_count), 26);
        fl.rename_freelist_req       = 4'b1111;
        fl.commit_freelist_valid     = 4'b0011;
        fl.commit_freelist_old_id[0] = 6'd1;
        fl.commit_freelist_old_id[1] = 6'd2;
        fl.commit_freelist_restore   = 1'b1;
        #1;
        chk("flush_ready", 32'(fl.freelist_rename_ready), 0);
        step();
        clear_in();
        fl.rename_freelist_req = 4'b0001;
        #1;
        chk("flush_id0", 32'(fl.freelist_rename_id[0]), 34);
        chk("flush_free", 32'(fl.freelist_free_count), 32);
        step();
        clear_in();

        // Overflow error is sticky
        do_reset();
        model_en = 1'b0;
        fl.commit_freelist_valid     = 4'b0001;
        fl.commit_freelist_old_id[0] = 6'd9;
        #1;
        chk("err_before", 32'(fl.freelist_overflow_err), 0);
        step();
        fl.commit_freelist_valid = '0;
        #1;
        chk("err_set", 32'(fl.freelist_overflow_err), 1);
        repeat (3) step();
        chk("err_sticky", 32'(fl.freelist_overflow_err), 1);

        // Asynchronous reset between edges
        fl.rename_freelist_req = 4'b1111;
        step();
        step();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_free_count", 32'(fl.freelist_free_count), 32);
        chk("async_id0", 32'(fl.freelist_rename_id[0]), 32);
        chk("async_err_clear", 32'(fl.freelist_overflow_err), 0);
        clear_in();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        model_en = 1'b1;

        // Random traffic, commits limited to outstanding allocations
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] v;
            fl.rename_freelist_req = 4'($urandom_range(0, 15));
            v = 4'($urandom_range(0, 15));
            for (int b = 3; b >= 0; b--) if (pc(32'(v)) > spec_n) v[b] = 1'b0;
            fl.commit_freelist_valid = v;
            for (int j = 0; j < COMMIT_WIDTH; j++)
                fl.commit_freelist_old_id[j] = 6'($urandom_range(0, 63));
            fl.commit_freelist_restore = ($urandom_range(0, 31) == 0);
            step();
        end
        clear_in();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
